// File: rtl/int_vector_divide_stage_if.sv
// Operand-fetch / writeback bundle for the vector divide unit.
// A transfer happens on a rising edge where valid and ready are both high;
// once valid is raised the producer holds it and its payload until that edge.
interface int_vector_divide_stage_if #(
  parameter int NUM_LANES        = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_IDX_WIDTH = 2,
  parameter int TAG_WIDTH        = 8
);
  logic                              of_valid;
  logic                              of_ready;
  logic [1:0]                        of_op;
  logic [NUM_LANES*DATA_WIDTH-1:0]   of_operand1;
  logic [NUM_LANES*DATA_WIDTH-1:0]   of_operand2;
  logic [NUM_LANES-1:0]              of_mask;
  logic [THREAD_IDX_WIDTH-1:0]       of_thread_idx;
  logic [TAG_WIDTH-1:0]              of_tag;
  logic                              wb_rollback_en;
  logic [THREAD_IDX_WIDTH-1:0]       wb_rollback_thread_idx;
  logic                              dv_valid;
  logic                              dv_accept;
  logic [NUM_LANES*DATA_WIDTH-1:0]   dv_result;
  logic [NUM_LANES-1:0]              dv_mask;
  logic [THREAD_IDX_WIDTH-1:0]       dv_thread_idx;
  logic [TAG_WIDTH-1:0]              dv_tag;
  logic [NUM_LANES-1:0]              dv_div_by_zero;

  modport master (
    output of_valid, of_op, of_operand1, of_operand2, of_mask, of_thread_idx, of_tag,
    output wb_rollback_en, wb_rollback_thread_idx, dv_accept,
    input  of_ready, dv_valid, dv_result, dv_mask, dv_thread_idx, dv_tag, dv_div_by_zero
  );

  modport slave (
    input  of_valid, of_op, of_operand1, of_operand2, of_mask, of_thread_idx, of_tag,
    input  wb_rollback_en, wb_rollback_thread_idx, dv_accept,
    output of_ready, dv_valid, dv_result, dv_mask, dv_thread_idx, dv_tag, dv_div_by_zero
  );
endinterface

// File: rtl/int_vector_divide_stage.sv
// Multi-cycle vector divide/remainder: per-lane radix-2 restoring divide,
// one quotient bit per cycle, single instruction in flight, rollback squash.
module int_vector_divide_stage #(
  parameter int NUM_LANES        = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_IDX_WIDTH = 2,
  parameter int TAG_WIDTH        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  int_vector_divide_stage_if.slave   bus,
  output logic [1:0]                 state_debug
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                      state, state_next;
  logic [CW-1:0]               count;
  logic [1:0]                  op_q;
  logic [NUM_LANES-1:0]        mask_q, s1_q, s2_q, dbz_q;
  logic [THREAD_IDX_WIDTH-1:0] thread_q;
  logic [TAG_WIDTH-1:0]        tag_q;
  logic [NUM_LANES*W-1:0]      result_q;
  logic [W-1:0]                rem_q [NUM_LANES];
  logic [W-1:0]                quo_q [NUM_LANES];
  logic [W-1:0]                dvs_q [NUM_LANES];

  logic [W-1:0]                a_in [NUM_LANES];
  logic [W-1:0]                b_in [NUM_LANES];
  logic [NUM_LANES-1:0]        a_neg, b_neg, dz;
  logic [W:0]                  wide [NUM_LANES];
  logic [W+1:0]                diff [NUM_LANES];
  logic [W-1:0]                rem_next [NUM_LANES];
  logic [W-1:0]                quo_next [NUM_LANES];
  logic [W-1:0]                q_fix [NUM_LANES];
  logic [W-1:0]                r_fix [NUM_LANES];
  logic [W-1:0]                res [NUM_LANES];

  logic of_ready, of_kill, busy_kill, accept, last_iter;

  assign of_ready  = (state == IDLE);
  assign of_kill   = bus.wb_rollback_en && (bus.wb_rollback_thread_idx == bus.of_thread_idx);
  assign busy_kill = bus.wb_rollback_en && (bus.wb_rollback_thread_idx == thread_q);
  assign accept    = bus.of_valid && of_ready && !of_kill;
  assign last_iter = (count == CW'(W));

  assign bus.of_ready       = of_ready;
  assign bus.dv_valid       = (state == DONE) && !busy_kill;
  assign bus.dv_result      = result_q;
  assign bus.dv_mask        = mask_q;
  assign bus.dv_thread_idx  = thread_q;
  assign bus.dv_tag         = tag_q;
  assign bus.dv_div_by_zero = dbz_q;
  assign state_debug        = state;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (busy_kill) state_next = IDLE;
               else if (last_iter) state_next = DONE;
      DONE:    if (busy_kill || bus.dv_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      a_in[i]     = bus.of_operand1[i*W +: W];
      b_in[i]     = bus.of_operand2[i*W +: W];
      a_neg[i]    = bus.of_op[0] && a_in[i][W-1];
      b_neg[i]    = bus.of_op[0] && b_in[i][W-1];
      wide[i]     = {rem_q[i], quo_q[i][W-1]};
      diff[i]     = {1'b0, wide[i]} - {2'b00, dvs_q[i]};
      rem_next[i] = diff[i][W+1] ? wide[i][W-1:0] : diff[i][W-1:0];
      quo_next[i] = {quo_q[i][W-2:0], ~diff[i][W+1]};
      q_fix[i]    = (s1_q[i] != s2_q[i]) ? -quo_q[i] : quo_q[i];
      // A zero divisor leaves the dividend magnitude in rem_q, so r_fix
      // already equals the original dividend for both signed and unsigned.
      r_fix[i]    = s1_q[i] ? -rem_q[i] : rem_q[i];
      dz[i]       = (dvs_q[i] == '0);
      res[i]      = '0;
      if (mask_q[i]) res[i] = op_q[1] ? r_fix[i] : (dz[i] ? '1 : q_fix[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      mask_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      dbz_q    <= '0;
      thread_q <= '0;
      tag_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rem_q[i] <= '0;
        quo_q[i] <= '0;
        dvs_q[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (accept) begin
        count    <= '0;
        op_q     <= bus.of_op;
        mask_q   <= bus.of_mask;
        thread_q <= bus.of_thread_idx;
        tag_q    <= bus.of_tag;
        s1_q     <= a_neg;
        s2_q     <= b_neg;
        for (int i = 0; i < NUM_LANES; i++) begin
          rem_q[i] <= '0;
          quo_q[i] <= a_neg[i] ? -a_in[i] : a_in[i];
          dvs_q[i] <= b_neg[i] ? -b_in[i] : b_in[i];
        end
      end else if (state == RUN && !last_iter) begin
        count <= count + CW'(1);
        for (int i = 0; i < NUM_LANES; i++) begin
          rem_q[i] <= rem_next[i];
          quo_q[i] <= quo_next[i];
        end
      end else if (state == RUN && !busy_kill) begin
        dbz_q <= mask_q & dz;
        for (int i = 0; i < NUM_LANES; i++) result_q[i*W +: W] <= res[i];
      end
    end
  end
endmodule

// File: tb/tb_int_vector_divide_stage.sv
// Directed + random scoreboard bench for int_vector_divide_stage.
module tb_int_vector_divide_stage;
  localparam int NL    = 4;
  localparam int W     = 32;
  localparam int TW    = 2;
  localparam int GW    = 8;
  localparam int RW    = NL * W;
  localparam int EXP_W = TW + GW + NL + NL + RW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_debug;
  int         checks = 0;
  int         errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  int_vector_divide_stage_if #(.NUM_LANES(NL), .DATA_WIDTH(W),
    .THREAD_IDX_WIDTH(TW), .TAG_WIDTH(GW)) bus ();

  int_vector_divide_stage #(.NUM_LANES(NL), .DATA_WIDTH(W),
    .THREAD_IDX_WIDTH(TW), .TAG_WIDTH(GW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_debug(state_debug));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] observed();
    return {bus.dv_thread_idx, bus.dv_tag, bus.dv_mask, bus.dv_div_by_zero, bus.dv_result};
  endfunction

  function automatic logic [W-1:0] lane_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return a / b;
      2'b01:   return $signed(a) / $signed(b);
      2'b10:   return a % b;
      default: return $signed(a) % $signed(b);
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // driver: called at a negedge with the unit idle
  task automatic send(input logic [1:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                      input logic [NL-1:0] mask, input logic [TW-1:0] thr,
                      input logic [GW-1:0] tag, input bit push);
    logic [RW-1:0] res;
    logic [NL-1:0] dz;
    check("ready_at_send", bus.of_ready, 1'b1);
    bus.of_valid = 1'b1;
    bus.of_op = op;
    bus.of_operand1 = a;
    bus.of_operand2 = b;
    bus.of_mask = mask;
    bus.of_thread_idx = thr;
    bus.of_tag = tag;
    for (int i = 0; i < NL; i++) begin
      res[i*W +: W] = mask[i] ? lane_res(op, a[i*W +: W], b[i*W +: W]) : '0;
      dz[i] = mask[i] && (b[i*W +: W] == '0);
    end
    @(posedge clk);
    if (push) exp_q.push_back({thr, tag, mask, dz, res});
    @(negedge clk);
    bus.of_valid = 1'b0;
  endtask

  // consumer: waits for dv_valid, holds off accept for 'hold' cycles
  task automatic expect_result(input int hold);
    int n;
    logic [EXP_W-1:0] e;
    n = 0;
    while (bus.dv_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 33);
    check("exp_pending", exp_q.size() != 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int k = 0; k <= hold; k++) begin
      check("dv_fields", observed(), e);
      check("dv_valid_held", bus.dv_valid, 1'b1);
      check("of_ready_busy", bus.of_ready, 1'b0);
      if (k < hold) @(negedge clk);
    end
    bus.dv_accept = 1'b1;
    @(negedge clk);
    bus.dv_accept = 1'b0;
    check("of_ready_after_accept", bus.of_ready, 1'b1);
    check("dv_valid_after_accept", bus.dv_valid, 1'b0);
  endtask

  initial begin
    bit seen;
    logic [RW-1:0] a, b;
    bus.of_valid = 0; bus.of_op = 0; bus.of_operand1 = 0; bus.of_operand2 = 0;
    bus.of_mask = 0; bus.of_thread_idx = 0; bus.of_tag = 0;
    bus.wb_rollback_en = 0; bus.wb_rollback_thread_idx = 0; bus.dv_accept = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", observed(), '0);
    check("reset_dv_valid", bus.dv_valid, 1'b0);
    check("reset_of_ready", bus.of_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // DIVU with inactive lanes carrying nonzero operands
    send(2'b00, {32'd50, 32'd9, 32'hFFFF_FFFF, 32'd100}, {32'd5, 32'd3, 32'd1, 32'd7},
         4'b0011, 2'd0, 8'h11, 1'b1);
    expect_result(0);

    // DIVS / REMS including most-negative / -1
    send(2'b01, {64'd0, 32'h8000_0000, 32'hFFFF_FFF9}, {64'd0, 32'hFFFF_FFFF, 32'd2},
         4'b0011, 2'd1, 8'h22, 1'b1);
    expect_result(1);
    send(2'b11, {64'd0, 32'h8000_0000, 32'hFFFF_FFF9}, {64'd0, 32'hFFFF_FFFF, 32'd2},
         4'b0011, 2'd1, 8'h23, 1'b1);
    expect_result(0);

    // divide by zero, active and masked off
    send(2'b01, {64'd0, 32'd9, 32'hFFFF_FFFB}, {64'd0, 32'd0, 32'd0}, 4'b0001, 2'd2, 8'h33, 1'b1);
    expect_result(0);
    send(2'b10, {64'd0, 32'd9, 32'd9}, {64'd0, 32'd0, 32'd0}, 4'b0001, 2'd3, 8'h34, 1'b1);
    expect_result(0);

    // backpressure for 10 cycles, then back-to-back accept
    send(2'b10, {32'd77, 32'd1000, 32'd13, 32'd100}, {32'd8, 32'd7, 32'd0, 32'd7},
         4'b1111, 2'd0, 8'h44, 1'b1);
    expect_result(10);
    send(2'b00, {32'd81, 32'd64, 32'd15, 32'd1}, {32'd9, 32'd8, 32'd4, 32'd2},
         4'b1110, 2'd3, 8'h45, 1'b1);
    expect_result(0);

    // rollback of the busy thread mid-run: squashed
    send(2'b00, {4{32'd1234}}, {4{32'd3}}, 4'b1111, 2'd2, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd2;
    @(negedge clk);
    bus.wb_rollback_en = 1'b0;
    check("squash_ready", bus.of_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.dv_valid) seen = 1'b1;
    end
    check("squash_no_valid", seen, 1'b0);

    // rollback of another thread while busy: no effect
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd1;
    send(2'b01, {32'hFFFF_FF9C, 32'd50, 32'hFFFF_FFF0, 32'd21}, {32'd7, 32'hFFFF_FFFB, 32'd3, 32'd4},
         4'b1111, 2'd2, 8'h66, 1'b1);
    expect_result(0);
    bus.wb_rollback_en = 1'b0;

    // rollback coincident with of_valid of same thread: not accepted
    bus.of_valid = 1'b1;
    bus.of_thread_idx = 2'd3;
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd3;
    @(negedge clk);
    check("coincident_not_accepted", bus.of_ready, 1'b1);
    bus.of_valid = 1'b0;
    bus.wb_rollback_en = 1'b0;

    // rollback and dv_accept together in DONE: rollback wins
    send(2'b00, {4{32'd99}}, {4{32'd9}}, 4'b1111, 2'd1, 8'h77, 1'b0);
    repeat (33) @(negedge clk);
    check("done_before_rollback", bus.dv_valid, 1'b1);
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd1;
    bus.dv_accept = 1'b1;
    #1;
    check("rollback_masks_valid", bus.dv_valid, 1'b0);
    @(negedge clk);
    bus.wb_rollback_en = 1'b0;
    bus.dv_accept = 1'b0;
    check("rollback_done_idle", bus.of_ready, 1'b1);
    check("rollback_done_no_valid", bus.dv_valid, 1'b0);

    // reset at iteration 20, then a fresh op
    send(2'b11, {4{32'd12345}}, {4{32'd17}}, 4'b1111, 2'd3, 8'h88, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_outputs", observed(), '0);
    check("midreset_valid", bus.dv_valid, 1'b0);
    check("midreset_ready", bus.of_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(2'b10, {32'd3, 32'd4000000000, 32'd17, 32'd1000}, {32'd5, 32'd3, 32'd17, 32'd33},
         4'b1011, 2'd1, 8'h99, 1'b1);
    expect_result(0);

    // random ops with edge-value operands
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NL; i++) begin
        a[i*W +: W] = pick();
        b[i*W +: W] = pick();
      end
      send(2'($urandom_range(0, 3)), a, b, 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);
      expect_result($urandom_range(0, 3));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
